// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: command, write-beat and read-beat channels of
// the burst controller; master drives commands, slave serves them.
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              done;
  logic              busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  rd_last, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output rd_last, done, busy
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write front-end for a synchronous SRAM.
// Define MEM_BURST_WRAP_ERR_EN to reject bursts crossing the top address.
module mem_burst_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_burst_ctrl_if.slave   bus,
  output logic              mem_cs,
  output logic              mem_w_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out
`ifdef MEM_BURST_WRAP_ERR_EN
  ,
  output logic              err
`endif
);
  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;
  logic              cmd_ready;
  logic              wr_ready;
  logic              rd_valid;
  logic              rd_last;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              issue_last;
  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] lst_sr;
  logic              rd_fin;
  logic              wrap_err;

`ifdef MEM_BURST_WRAP_ERR_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, bus.cmd_addr} + (ADDR_W+1)'(bus.cmd_len);
  assign wrap_err = end_addr > {1'b0, {ADDR_W{1'b1}}};
`else
  assign wrap_err = 1'b0;
`endif

  assign rd_fin        = vld_sr[RD_LAT-1] & lst_sr[RD_LAT-1];
  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.rd_last   = rd_last;
  assign bus.done      = done;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      wr_ready   <= 1'b0;
      done       <= 1'b0;
      mem_cs     <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_addr   <= '0;
      mem_d_in   <= '0;
      cur_addr   <= '0;
      beats_left <= '0;
      issue_last <= 1'b0;
      vld_sr     <= '0;
      lst_sr     <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
`ifdef MEM_BURST_WRAP_ERR_EN
      err        <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      cmd_ready  <= 1'b0;
      mem_cs     <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_r_en   <= 1'b0;
      issue_last <= 1'b0;
`ifdef MEM_BURST_WRAP_ERR_EN
      err        <= 1'b0;
`endif
      // read-latency tracker follows the registered read strobe
      vld_sr[0] <= mem_r_en;
      lst_sr[0] <= mem_r_en & issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        lst_sr[i] <= lst_sr[i-1];
      end
      rd_valid <= vld_sr[RD_LAT-1];
      rd_last  <= rd_fin;
      if (vld_sr[RD_LAT-1]) rd_data <= mem_d_out;

      unique case (state)
        IDLE: begin
          cmd_ready <= !(bus.cmd_valid && cmd_ready);
          if (bus.cmd_valid && cmd_ready) begin
            cur_addr   <= bus.cmd_addr;
            beats_left <= bus.cmd_len;
            if (wrap_err) begin
              done <= 1'b1;
`ifdef MEM_BURST_WRAP_ERR_EN
              err  <= 1'b1;
`endif
            end else if (bus.cmd_write) begin
              wr_ready <= 1'b1;
              state    <= WRITE;
            end else begin
              state    <= READ;
            end
          end
        end
        WRITE: begin
          if (bus.wr_valid && wr_ready) begin
            mem_cs   <= 1'b1;
            mem_w_en <= 1'b1;
            mem_addr <= cur_addr;
            mem_d_in <= bus.wr_data;
            cur_addr <= cur_addr + ADDR_W'(1);
            if (beats_left == '0) begin
              wr_ready <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              beats_left <= beats_left - LEN_W'(1);
            end
          end
        end
        READ: begin
          mem_cs   <= 1'b1;
          mem_r_en <= 1'b1;
          mem_addr <= cur_addr;
          cur_addr <= cur_addr + ADDR_W'(1);
          if (beats_left == '0) begin
            issue_last <= 1'b1;
            state      <= DRAIN;
          end else begin
            beats_left <= beats_left - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (rd_fin) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized bursts against an SRAM model and a
// byte-level scoreboard of what each address should hold.
module tb_mem_burst_ctrl;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_ctrl_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) bus ();

  logic              mem_cs;
  logic              mem_w_en;
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d_in;
  logic [DATA_W-1:0] mem_d_out;
`ifdef MEM_BURST_WRAP_ERR_EN
  logic              err;
`endif

  mem_burst_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .mem_cs(mem_cs),
    .mem_w_en(mem_w_en),
    .mem_r_en(mem_r_en),
    .mem_addr(mem_addr),
    .mem_d_in(mem_d_in),
    .mem_d_out(mem_d_out)
`ifdef MEM_BURST_WRAP_ERR_EN
    ,
    .err(err)
`endif
  );

  // synchronous SRAM with RD_LAT cycles of read latency
  logic [7:0] mem [DEPTH];
  logic [7:0] rp [RD_LAT];
  always @(posedge clk) begin
    if (mem_cs && mem_w_en) mem[mem_addr] <= mem_d_in;
    if (mem_cs && mem_r_en) rp[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
  end
  assign mem_d_out = rp[RD_LAT-1];

  logic [7:0] ref_mem [int];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wl_addr[$], wl_data[$], wl_cyc[$];
  int rl_addr[$], rl_cyc[$];
  int rv_data[$], rv_last[$], rv_cyc[$];
  int dn_cyc[$], ac_cyc[$], er_cyc[$], cs_cyc[$];
  int excl_viol = 0;
  int wrr_cnt = 0;

  always @(negedge clk) begin
    #4;
    if (mem_w_en && mem_r_en) excl_viol++;
    if (!mem_cs && (mem_w_en || mem_r_en)) excl_viol++;
    if (mem_cs) cs_cyc.push_back(cyc);
    if (mem_cs && mem_w_en) begin
      wl_addr.push_back(int'(mem_addr));
      wl_data.push_back(int'(mem_d_in));
      wl_cyc.push_back(cyc);
    end
    if (mem_cs && mem_r_en) begin
      rl_addr.push_back(int'(mem_addr));
      rl_cyc.push_back(cyc);
    end
    if (bus.rd_valid) begin
      rv_data.push_back(int'(bus.rd_data));
      rv_last.push_back(int'(bus.rd_last));
      rv_cyc.push_back(cyc);
    end
    if (bus.done) dn_cyc.push_back(cyc);
    if (bus.wr_ready) wrr_cnt++;
    if (bus.cmd_valid && bus.cmd_ready) ac_cyc.push_back(cyc);
`ifdef MEM_BURST_WRAP_ERR_EN
    if (err) er_cyc.push_back(cyc);
`endif
  end

  task automatic clear_logs();
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
    rl_addr.delete(); rl_cyc.delete();
    rv_data.delete(); rv_last.delete(); rv_cyc.delete();
    dn_cyc.delete(); ac_cyc.delete(); er_cyc.delete();
    cs_cyc.delete();
    wrr_cnt = 0;
  endtask

  task automatic send_cmd(input logic w, input int addr, input int len);
    int t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = ADDR_W'(addr);
    bus.cmd_len   = LEN_W'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed_beats(input logic [7:0] d[$], input int gap[$]);
    int i = 0;
    int g = 0;
    int t = 0;
    logic fire;
    while (i < d.size() && t < 4000) begin
      if (g < gap[i]) begin
        bus.wr_valid = 1'b0;
        g++;
      end else begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = d[i];
      end
      fire = bus.wr_valid && bus.wr_ready;
      @(negedge clk);
      t++;
      if (fire) begin
        i++;
        g = 0;
      end
    end
    bus.wr_valid = 1'b0;
    if (i < d.size()) begin
      vectors++; miscompares++;
      $display("FAIL wr_beats: accepted=%0d required %0d", i, d.size());
    end
  endtask

  task automatic settle();
    repeat (RD_LAT + 4) @(negedge clk);
  endtask

  task automatic run_write(input int addr, input int len,
                           input logic [7:0] d[$], input int gap[$]);
    clear_logs();
    send_cmd(1'b1, addr, len);
    feed_beats(d, gap);
    for (int k = 0; k <= len; k++) ref_mem[(addr + k) % DEPTH] = d[k];
    settle();
  endtask

  task automatic run_read(input int addr, input int len);
    int t = 0;
    clear_logs();
    send_cmd(1'b0, addr, len);
    while (dn_cyc.size() == 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (dn_cyc.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL rd_done_wait: done count=0 required 1");
    end
    settle();
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
    bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last,
         bus.done, bus.busy, mem_cs, mem_w_en, mem_r_en} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: flags=%b required 0", {bus.cmd_ready,
        bus.wr_ready, bus.rd_valid, bus.rd_last, bus.done, bus.busy,
        mem_cs, mem_w_en, mem_r_en});
    end
    vectors++;
    if ({bus.rd_data, mem_addr, mem_d_in} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: rd_data=%h addr=%h d_in=%h required 0",
               bus.rd_data, mem_addr, mem_d_in);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0",
               bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d[$] = '{8'd0, 8'd10, 8'd2, 8'd5, 8'd12};
    int gap[$] = '{0, 0, 0, 0, 0};
    int exp_rd[5] = '{0, 10, 2, 5, 12};
    run_write(0, 4, d, gap);
    vectors++;
    if (wl_addr.size() !== 5) begin
      miscompares++;
      $display("FAIL basic_wr_count: got %0d required 5", wl_addr.size());
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (wl_addr[k] !== k || wl_data[k] !== exp_rd[k] ||
          wl_cyc[k] !== wl_cyc[0] + k) begin
        miscompares++;
        $display("FAIL basic_wr_beat%0d: addr=%0d data=%0d dcyc=%0d required %0d %0d %0d",
                 k, wl_addr[k], wl_data[k], wl_cyc[k] - wl_cyc[0], k, exp_rd[k], k);
      end
    end
    vectors++;
    if (dn_cyc.size() !== 1 || dn_cyc[0] !== wl_cyc[4]) begin
      miscompares++;
      $display("FAIL basic_wr_done: n=%0d cyc=%0d required 1 %0d",
               dn_cyc.size(), dn_cyc[0], wl_cyc[4]);
    end
    run_read(0, 4);
    vectors++;
    if (rv_data.size() !== 5) begin
      miscompares++;
      $display("FAIL basic_rd_count: got %0d required 5", rv_data.size());
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rv_data[k] !== exp_rd[k] || rv_last[k] !== int'(k == 4) ||
          rv_cyc[k] !== rl_cyc[k] + RD_LAT + 1) begin
        miscompares++;
        $display("FAIL basic_rd_beat%0d: data=%0d last=%0d lat=%0d required %0d %0d %0d",
                 k, rv_data[k], rv_last[k], rv_cyc[k] - rl_cyc[k],
                 exp_rd[k], int'(k == 4), RD_LAT + 1);
      end
    end
    vectors++;
    if (dn_cyc.size() !== 1 || dn_cyc[0] !== rv_cyc[4]) begin
      miscompares++;
      $display("FAIL basic_rd_done: n=%0d cyc=%0d required 1 %0d",
               dn_cyc.size(), dn_cyc[0], rv_cyc[4]);
    end
  endtask

  task automatic test_gap();
    logic [7:0] d[$];
    int gap[$] = '{0, 0, 2, 0};
    int exp_dc[4] = '{0, 1, 4, 5};
    for (int k = 0; k < 4; k++) d.push_back(8'($urandom));
    run_write(100, 3, d, gap);
    vectors++;
    if (cs_cyc.size() !== 4 || wl_addr.size() !== 4) begin
      miscompares++;
      $display("FAIL gap_cs_count: cs=%0d writes=%0d required 4 4",
               cs_cyc.size(), wl_addr.size());
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wl_addr[k] !== 100 + k || wl_data[k] !== int'(d[k]) ||
          wl_cyc[k] - wl_cyc[0] !== exp_dc[k]) begin
        miscompares++;
        $display("FAIL gap_beat%0d: addr=%0d data=%0d dcyc=%0d required %0d %0d %0d",
                 k, wl_addr[k], wl_data[k], wl_cyc[k] - wl_cyc[0],
                 100 + k, d[k], exp_dc[k]);
      end
    end
  endtask

  task automatic test_wrap();
`ifdef MEM_BURST_WRAP_ERR_EN
    clear_logs();
    send_cmd(1'b1, 'h3FFFE, 3);
    settle();
    vectors++;
    if (er_cyc.size() !== 1 || dn_cyc.size() !== 1 ||
        er_cyc[0] !== dn_cyc[0] || er_cyc[0] !== ac_cyc[0] + 1) begin
      miscompares++;
      $display("FAIL wrap_err_pulse: err=%0d done=%0d ecyc=%0d required 1 1 %0d",
               er_cyc.size(), dn_cyc.size(), er_cyc[0], ac_cyc[0] + 1);
    end
    vectors++;
    if (cs_cyc.size() !== 0 || wrr_cnt !== 0 || rv_data.size() !== 0) begin
      miscompares++;
      $display("FAIL wrap_err_quiet: cs=%0d wr_ready=%0d rd=%0d required 0 0 0",
               cs_cyc.size(), wrr_cnt, rv_data.size());
    end
`else
    logic [7:0] d[$] = '{8'd1, 8'd2, 8'd3, 8'd4};
    int gap[$] = '{0, 0, 0, 0};
    int exp_a[4] = '{'h3FFFE, 'h3FFFF, 0, 1};
    run_write('h3FFFE, 3, d, gap);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wl_addr[k] !== exp_a[k]) begin
        miscompares++;
        $display("FAIL wrap_wr_addr%0d: got %h required %h", k, wl_addr[k], exp_a[k]);
      end
    end
    run_read('h3FFFE, 3);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (rv_data[k] !== k + 1 || rl_addr[k] !== exp_a[k]) begin
        miscompares++;
        $display("FAIL wrap_rd%0d: data=%0d addr=%h required %0d %h",
                 k, rv_data[k], rl_addr[k], k + 1, exp_a[k]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    int t = 0;
    int n_rd;
    int n_dn;
    clear_logs();
    send_cmd(1'b0, 0, 7);
    while (!(rl_cyc.size() == 2 && mem_r_en) && t < 50) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_rd = rv_data.size();
    n_dn = dn_cyc.size();
    vectors++;
    if ({mem_cs, mem_w_en, mem_r_en, bus.rd_valid, bus.busy,
         bus.cmd_ready} !== 6'b0 || mem_addr !== '0) begin
      miscompares++;
      $display("FAIL rstmid_state: flags=%b addr=%h required 0 0",
               {mem_cs, mem_w_en, mem_r_en, bus.rd_valid, bus.busy,
                bus.cmd_ready}, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (rv_data.size() !== n_rd || dn_cyc.size() !== n_dn) begin
      miscompares++;
      $display("FAIL rstmid_flush: rd_valid beats=%0d done=%0d required %0d %0d",
               rv_data.size(), dn_cyc.size(), n_rd, n_dn);
    end
  endtask

  task automatic test_busy_holdoff();
    logic [7:0] d[$];
    int gap[$] = '{0, 0, 0};
    int t = 0;
    for (int k = 0; k < 3; k++) d.push_back(8'($urandom));
    clear_logs();
    excl_viol = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = ADDR_W'(200);
    bus.cmd_len   = LEN_W'(2);
    @(negedge clk);
    bus.cmd_write = 1'b0;
    feed_beats(d, gap);
    for (int k = 0; k < 3; k++) ref_mem[200 + k] = d[k];
    t = 0;
    while (ac_cyc.size() < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    bus.cmd_valid = 1'b0;
    t = 0;
    while (dn_cyc.size() < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    settle();
    vectors++;
    if (ac_cyc.size() !== 2 || ac_cyc[1] !== dn_cyc[0] + 1) begin
      miscompares++;
      $display("FAIL holdoff_accept: n=%0d cyc=%0d required 2 %0d",
               ac_cyc.size(), ac_cyc[1], dn_cyc[0] + 1);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rv_data[k] !== int'(ref_mem[200 + k])) begin
        miscompares++;
        $display("FAIL holdoff_rd%0d: got %0d required %0d",
                 k, rv_data[k], ref_mem[200 + k]);
      end
    end
    vectors++;
    if (excl_viol !== 0) begin
      miscompares++;
      $display("FAIL holdoff_excl: violations=%0d required 0", excl_viol);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] d[$];
      int gap[$];
      int len = int'($urandom_range(0, 15));
      int addr = int'($urandom_range(0, DEPTH - 1 - len));
      for (int k = 0; k <= len; k++) begin
        d.push_back(8'($urandom));
        gap.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      run_write(addr, len, d, gap);
      vectors++;
      if (wl_addr.size() !== len + 1 || dn_cyc[0] !== wl_cyc[len]) begin
        miscompares++;
        $display("FAIL rnd%0d_wr: writes=%0d done=%0d required %0d %0d",
                 it, wl_addr.size(), dn_cyc[0], len + 1, wl_cyc[len]);
      end
      for (int k = 0; k <= len; k++) begin
        vectors++;
        if (wl_addr[k] !== addr + k || wl_data[k] !== int'(d[k])) begin
          miscompares++;
          $display("FAIL rnd%0d_wr%0d: addr=%0d data=%0d required %0d %0d",
                   it, k, wl_addr[k], wl_data[k], addr + k, d[k]);
        end
      end
      run_read(addr, len);
      vectors++;
      if (rv_data.size() !== len + 1 || dn_cyc[0] !== rv_cyc[len]) begin
        miscompares++;
        $display("FAIL rnd%0d_rd: beats=%0d done=%0d required %0d %0d",
                 it, rv_data.size(), dn_cyc[0], len + 1, rv_cyc[len]);
      end
      for (int k = 0; k <= len; k++) begin
        vectors++;
        if (rv_data[k] !== int'(ref_mem[addr + k]) ||
            rv_last[k] !== int'(k == len) ||
            rl_cyc[k] !== rl_cyc[0] + k ||
            rv_cyc[k] !== rl_cyc[k] + RD_LAT + 1) begin
          miscompares++;
          $display("FAIL rnd%0d_rd%0d: data=%0d last=%0d lat=%0d required %0d %0d %0d",
                   it, k, rv_data[k], rv_last[k], rv_cyc[k] - rl_cyc[k],
                   ref_mem[addr + k], int'(k == len), RD_LAT + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_wrap();
    test_reset_mid_read();
    test_busy_holdoff();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Request front-end directly upstream of the 256K x 8 synchronous `memory` array (ports cs, addr, d_in, w_en, r_en, d_out).
- Accepts burst read/write commands on a valid/ready interface and streams write data in and read data out.
- Drives the memory's chip-select, enables, address and data with registered outputs, auto-incrementing the address, one beat per cycle.

Parameters:
- ADDR_W, 18, memory address width
- DATA_W, 8, data width
- LEN_W, 8, burst length field width (beats = cmd_len+1, max 256)
- RD_LAT, 1, cycles from a memory read-enable cycle to valid mem_d_out (1..4)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, command accepted when valid&ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat present
- wr_ready  out  1  write beat accepted when valid&ready
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat valid (no backpressure)
- rd_data  out  DATA_W  read beat data
- rd_last  out  1  final beat of read burst, qualified by rd_valid
- done  out  1  one-cycle pulse at burst completion
- busy  out  1  high whenever state != IDLE
- mem_cs, mem_w_en, mem_r_en  out  1 each  memory controls, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_d_in  out  DATA_W  memory write data, registered
- mem_d_out  in  DATA_W  memory read data

Behaviour:
- Reset values: cmd_ready=0 during rst, 1 the cycle after. All other outputs 0: wr_ready, rd_valid, rd_data, rd_last, done, busy, mem_*. State IDLE.
- Reset mid-burst: next edge returns to IDLE with mem_* low. Pending read-latency pipeline is flushed, so no rd_valid after reset. No done pulse.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr, len and dir into cur_addr / beats_left and enter WRITE or READ.
  - WRITE: wr_ready=1.
    - Each accepted beat in cycle N produces, in cycle N+1: mem_cs=1, mem_w_en=1, mem_addr=cur_addr, mem_d_in=wr_data.
    - cur_addr increments. Beats with wr_valid=0 produce a cycle with mem_cs=0 (gaps allowed).
    - After the last beat is accepted: wr_ready drops the next cycle. done pulses in the same cycle as the final memory write pulse. Return to IDLE.
  - READ: one read is issued per cycle for cmd_len+1 consecutive cycles (mem_cs=1, mem_r_en=1, mem_addr=cur_addr), then enter DRAIN.
  - DRAIN: wait until the last read data returns, then go to IDLE.
- Read data timing: for a memory-side read cycle T, rd_valid=1 and rd_data=mem_d_out (registered) in cycle T+RD_LAT+1. This uses a RD_LAT-deep valid/last shift register. rd_last accompanies the final beat. done pulses with rd_last.
- Exclusivity: mem_w_en and mem_r_en are never high together. mem_cs=0 implies both enables are 0.
- Address arithmetic: cur_addr increments modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0 (unless the optional feature is enabled).
- Command acceptance: a cmd_valid during a burst is held off (cmd_ready=0). Back-to-back commands: the next command is accepted in the cycle after returning to IDLE, giving a minimum 1 idle cycle between bursts.
- cmd_len=0 gives a single-beat burst.

Optional Feature:
- Macro MEM_BURST_WRAP_ERR_EN.
- When defined:
  - Adds output port err (1 bit, reset 0).
  - A command with cmd_addr + cmd_len > 2^ADDR_W-1 is accepted but not executed: err and done pulse together one cycle after acceptance.
  - No mem_* activity, no wr_ready, no rd_valid; stays/returns IDLE.
- When undefined: no err port; address wraps to 0 as above.

Test Plan:
- Write burst: addr=0, len=4, data 0,10,2,5,12 with wr_valid continuous → mem_w_en high 5 consecutive cycles at addr 0..4, done on 5th, then read burst addr=0 len=4 returns rd_data 0,10,2,5,12 with rd_last on 12.
- Write with gap: wr_valid low for 2 cycles between beats 2 and 3 of addr=100 len=3 → mem_cs low exactly those 2 cycles, addresses 100..103 written in order.
- Wrap: write addr=0x3FFFE len=3 data 1..4 then read back → locations 0x3FFFE,0x3FFFF,0,1 hold 1,2,3,4 (with MEM_BURST_WRAP_ERR_EN defined: err+done pulse, no mem_cs, memory unchanged).
- Reset mid-read: read addr=0 len=7, assert rst at 3rd beat → next cycle mem_* all 0, no further rd_valid, cmd_ready=1 cycle after rst drops.
- Busy hold-off: cmd_valid asserted continuously during a len=2 write → second command accepted only the cycle after done; never mem_w_en & mem_r_en together.
- RD_LAT=3 build: read addr=1 len=1 → rd_valid exactly 4 cycles after each mem_r_en cycle, data matches prior writes.
